// File: rtl/io_pkg.sv
// Shared types and default timing constants for the board-input conditioner.
// No datapath of its own; the defaults assume a 23 MHz core clock.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } db_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 230000;
    localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-bit, DEPTH-stage synchroniser for asynchronous board inputs. Latency is DEPTH cycles.
// There is no backpressure. Bits outside RST_MASK keep sampling during reset.
module sync_ff #(
    parameter int               WIDTH    = 1,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RST_MASK = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            stage[0] <= d & ~RST_MASK;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1] & ~RST_MASK;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces the confirm button into one pulse per press and snapshots the switches and test select.
// Pulse latency is SYNC_STAGES+DEBOUNCE_CYCLES cycles after a clean press. There is no backpressure.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int SW_WIDTH        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    input  logic [2:0]          test_raw,
    input  logic                ecall_wait,
    output logic                confirm_pulse,
    output logic [SW_WIDTH-1:0] sw_value,
    output logic [2:0]          test_number,
    output logic                btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam int SW_BITS = 3 + SW_WIDTH + 1;

    // The test-select bits keep tracking in reset so test_number can capture the board setting.
    localparam logic [SW_BITS-1:0] SYNC_RST_MASK = {3'b000, {SW_WIDTH{1'b1}}, 1'b1};

    logic                btn_sync;
    logic [SW_WIDTH-1:0] sw_sync;
    logic [2:0]          test_sync;

    sync_ff #(
        .WIDTH    (SW_BITS),
        .DEPTH    (SYNC_STAGES),
        .RST_MASK (SYNC_RST_MASK)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({test_raw, sw_raw, btn_raw}),
        .q     ({test_sync, sw_sync, btn_sync})
    );

    db_state_t     state, state_next;
    logic [CW-1:0] cnt;
    logic          cnt_run;
    logic          pulse_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (btn_sync) state_next = PRESS_DB;
            end
            PRESS_DB: begin
                if (!btn_sync)            state_next = IDLE;
                else if (cnt == CNT_LAST) state_next = HELD;
            end
            HELD: begin
                if (!btn_sync) state_next = RELEASE_DB;
            end
            RELEASE_DB: begin
                if (btn_sync)             state_next = HELD;
                else if (cnt == CNT_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_run   = ((state == PRESS_DB) && btn_sync) || ((state == RELEASE_DB) && !btn_sync);
        pulse_set = (state == PRESS_DB) && (state_next == HELD);
        btn_level = (state == HELD) || (state == RELEASE_DB);
    end

    // Counter only runs while the qualified level is stable; any other sample clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_run) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            confirm_pulse <= 1'b0;
            sw_value      <= '0;
            test_number   <= test_sync;
        end else begin
            confirm_pulse <= pulse_set;
            if (pulse_set) sw_value <= sw_sync;
            if (pulse_set && !ecall_wait) test_number <= test_sync;
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
// It uses a table-driven clean press and release, followed by hand-written bounce and reset sequences.
module tb_io_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic [7:0] sw_raw;
    logic [2:0] test_raw;
    logic       ecall_wait;
    logic       confirm_pulse;
    logic [7:0] sw_value;
    logic [2:0] test_number;
    logic       btn_level;

    int checks = 0;
    int errors = 0;

    io_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .SW_WIDTH        (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .sw_raw        (sw_raw),
        .test_raw      (test_raw),
        .ecall_wait    (ecall_wait),
        .confirm_pulse (confirm_pulse),
        .sw_value      (sw_value),
        .test_number   (test_number),
        .btn_level     (btn_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic [7:0] sw;
        logic       exp_pulse;
        logic       exp_level;
        logic [7:0] exp_sw;
    } vec_t;

    vec_t tbl [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives pat[c] on btn_raw for cycle c (last bit repeats) and reports what was seen.
    task automatic run_btn(input logic [15:0] pat, input int n,
                           output int pulses, output int first_pulse, output int first_low);
        pulses      = 0;
        first_pulse = -1;
        first_low   = -1;
        for (int c = 0; c < n; c++) begin
            btn_raw = (c < 16) ? pat[c] : pat[15];
            tick();
            if (confirm_pulse === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = c;
            end
            if (btn_level === 1'b0 && first_low < 0) first_low = c;
        end
    endtask

    initial begin
        int p, fp, fl;

        // Clean press held 20 cycles, then a clean release; the switches change mid-hold.
        for (int i = 0; i < 20; i++) begin
            tbl[i].btn       = 1'b1;
            tbl[i].sw        = (i < 8) ? 8'hA5 : 8'h3C;
            tbl[i].exp_pulse = (i == 6);
            tbl[i].exp_level = (i >= 6);
            tbl[i].exp_sw    = (i >= 6) ? 8'hA5 : 8'h00;
        end
        for (int i = 20; i < 32; i++) begin
            tbl[i].btn       = 1'b0;
            tbl[i].sw        = 8'h3C;
            tbl[i].exp_pulse = 1'b0;
            tbl[i].exp_level = (i < 26);
            tbl[i].exp_sw    = 8'hA5;
        end

        reset      = 1'b1;
        btn_raw    = 1'b0;
        sw_raw     = 8'hFF;
        test_raw   = 3'd5;
        ecall_wait = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("reset_pulse", 32'(confirm_pulse), 32'd0);
        chk("reset_level", 32'(btn_level), 32'd0);
        chk("reset_sw_value", 32'(sw_value), 32'h00);
        chk("reset_test_number", 32'(test_number), 32'd5);

        reset  = 1'b0;
        sw_raw = 8'hA5;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_level", 32'(btn_level), 32'd0);

        for (int i = 0; i < 32; i++) begin
            btn_raw = tbl[i].btn;
            sw_raw  = tbl[i].sw;
            tick();
            chk($sformatf("clean_pulse[%0d]", i), 32'(confirm_pulse), 32'(tbl[i].exp_pulse));
            chk($sformatf("clean_level[%0d]", i), 32'(btn_level), 32'(tbl[i].exp_level));
            chk($sformatf("clean_sw[%0d]", i), 32'(sw_value), 32'(tbl[i].exp_sw));
        end

        // Press bounce: 1,1,0 then steady 1.
        run_btn(16'hFFFB, 20, p, fp, fl);
        chk("bounce_pulse_count", 32'(p), 32'd1);
        chk("bounce_pulse_cycle", 32'(fp), 32'd9);
        chk("bounce_new_snapshot", 32'(sw_value), 32'h3C);

        // Release bounce: 0,0,1 then steady 0.
        run_btn(16'h0004, 16, p, fp, fl);
        chk("release_bounce_pulses", 32'(p), 32'd0);
        chk("release_idle_cycle", 32'(fl), 32'd9);

        // Test select is frozen during an ecall wait and reloaded otherwise.
        ecall_wait = 1'b1;
        test_raw   = 3'd2;
        run_btn(16'hFFFF, 12, p, fp, fl);
        chk("ecall_press_pulses", 32'(p), 32'd1);
        chk("ecall_test_held", 32'(test_number), 32'd5);
        run_btn(16'h0000, 12, p, fp, fl);
        chk("ecall_release_level", 32'(btn_level), 32'd0);
        ecall_wait = 1'b0;
        run_btn(16'hFFFF, 12, p, fp, fl);
        chk("free_press_pulses", 32'(p), 32'd1);
        chk("free_test_loaded", 32'(test_number), 32'd2);
        run_btn(16'h0000, 12, p, fp, fl);

        // Reset lands in PRESS_DB at count 2 with the button held throughout.
        run_btn(16'hFFFF, 5, p, fp, fl);
        chk("pre_reset_pulses", 32'(p), 32'd0);
        reset = 1'b1;
        run_btn(16'hFFFF, 3, p, fp, fl);
        chk("in_reset_pulses", 32'(p), 32'd0);
        chk("in_reset_level", 32'(btn_level), 32'd0);
        reset = 1'b0;
        run_btn(16'hFFFF, 16, p, fp, fl);
        chk("post_reset_pulses", 32'(p), 32'd1);
        chk("post_reset_pulse_cycle", 32'(fp), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
